wfid_done_queue: RTL and testbench

Sits directly downstream of the VGPR write-port wavefront-ID mux. Captures every (muxed_wfid, muxed_wfid_done) completion event in an in-order FIFO. Hands events to the issue/retire logic over a valid/ack handshake, so a busy consumer never loses a done event. This decouples the single-cycle mux output from consumer back-pressure.

---
 rtl/vgpr_pkg.sv | 10 +
 rtl/wfid_done_queue_ptr.sv | 31 +++
 rtl/wfid_done_queue.sv | 123 ++++++++++++
 tb/tb_wfid_done_queue.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vgpr_pkg.sv
// Shared VGPR write-path definitions.
// Contents:
//   WFID_WIDTH            - width of a wavefront ID
//   WFID_DONE_QUEUE_DEPTH - default depth of the wavefront done-event queue
package vgpr_pkg;

  localparam int unsigned WFID_WIDTH            = 6;
  localparam int unsigned WFID_DONE_QUEUE_DEPTH = 8;

endpackage

// File: rtl/wfid_done_queue_ptr.sv
// Wrapping pointer counter with increment enable.
// The pointer wraps modulo 2**WIDTH, so the owning FIFO depth must be a power of two.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset, clears the pointer to 0
//   i_inc - advance the pointer by one on the next rising edge
//   o_ptr - current pointer value
module wfid_done_queue_ptr #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr
);

  localparam logic [WIDTH-1:0] PtrOne = WIDTH'(1);

  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + PtrOne;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/wfid_done_queue.sv
// In-order queue of wavefront completion events captured from the VGPR write-port
// wavefront-ID mux. Events are handed to the consumer over a valid/ack handshake so
// back-pressure never loses a done event (unless the queue is full with no pop).
// Optional feature macro: WFID_DONE_QUEUE_OVFL_ERR_EN adds a sticky ovfl_err output
// that flags a dropped push; it is cleared only by rst.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   muxed_wfid      - wavefront ID from the mux, sampled only when muxed_wfid_done=1
//   muxed_wfid_done - push strobe, one event per high cycle
//   out_valid       - head entry valid
//   out_wfid        - head entry wavefront ID
//   out_ack         - consumer accepts the head this cycle
//   count           - number of occupied entries (0..DEPTH)
//   full, empty     - registered occupancy flags
//   ovfl_err        - (macro only) sticky dropped-push flag
module wfid_done_queue
  import vgpr_pkg::*;
#(
  parameter int unsigned DEPTH     = WFID_DONE_QUEUE_DEPTH,
  parameter int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WFID_WIDTH-1:0] muxed_wfid,
  input  logic                  muxed_wfid_done,
  output logic                  out_valid,
  output logic [WFID_WIDTH-1:0] out_wfid,
  input  logic                  out_ack,
  output logic [PTR_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty
`ifdef WFID_DONE_QUEUE_OVFL_ERR_EN
  ,
  output logic                  ovfl_err
`endif
);

  localparam logic [PTR_WIDTH:0] CntOne  = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH:0] CntFull = (PTR_WIDTH + 1)'(DEPTH);

  logic [WFID_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH:0]    r_count;
  logic                  r_full;
  logic                  r_empty;
  logic [PTR_WIDTH:0]    w_count_d;
  logic [PTR_WIDTH-1:0]  w_wr_ptr;
  logic [PTR_WIDTH-1:0]  w_rd_ptr;
  logic                  w_push;
  logic                  w_pop;

  // A pop frees the head in the same cycle, so a full queue can still take a push.
  assign w_pop  = ~r_empty & out_ack;
  assign w_push = muxed_wfid_done & (~r_full | w_pop);

  wfid_done_queue_ptr #(
    .WIDTH (PTR_WIDTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_push),
    .o_ptr (w_wr_ptr)
  );

  wfid_done_queue_ptr #(
    .WIDTH (PTR_WIDTH)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_pop),
    .o_ptr (w_rd_ptr)
  );

  // Storage is intentionally not reset; only pushed (sampled) values are ever written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= muxed_wfid;
    end
  end

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CntOne;
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - CntOne;
    end
  end

  // Flags derive from the same next-count so they always agree with count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_d;
      r_full  <= (w_count_d == CntFull);
      r_empty <= (w_count_d == '0);
    end
  end

`ifdef WFID_DONE_QUEUE_OVFL_ERR_EN
  logic r_ovfl_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovfl_err <= 1'b0;
    end else if (muxed_wfid_done && !w_push) begin
      r_ovfl_err <= 1'b1;
    end
  end

  assign ovfl_err = r_ovfl_err;
`endif

  assign out_valid = ~r_empty;
  // Gate the unreset storage so the head reads 0 when nothing is queued.
  assign out_wfid  = r_empty ? '0 : r_mem[w_rd_ptr];
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;

endmodule

// File: tb/tb_wfid_done_queue.sv
// Directed bench for wfid_done_queue with a queue-based scoreboard.
// Optional macro WFID_DONE_QUEUE_OVFL_ERR_EN enables checks of ovfl_err.
module tb_wfid_done_queue;

  localparam int Depth = 8;

  logic       clk;
  logic       rst;
  logic [5:0] muxed_wfid;
  logic       muxed_wfid_done;
  logic       out_valid;
  logic [5:0] out_wfid;
  logic       out_ack;
  logic [3:0] count;
  logic       full;
  logic       empty;
`ifdef WFID_DONE_QUEUE_OVFL_ERR_EN
  logic       ovfl_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];
  bit m_ovfl   = 0;

  wfid_done_queue dut (
    .clk             (clk),
    .rst             (rst),
    .muxed_wfid      (muxed_wfid),
    .muxed_wfid_done (muxed_wfid_done),
    .out_valid       (out_valid),
    .out_wfid        (out_wfid),
    .out_ack         (out_ack),
    .count           (count),
    .full            (full),
    .empty           (empty)
`ifdef WFID_DONE_QUEUE_OVFL_ERR_EN
    ,
    .ovfl_err        (ovfl_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_wfid"},  32'(out_wfid),  32'd0);
    chk({tag, "_count"}, 32'(count),     32'd0);
    chk({tag, "_empty"}, 32'(empty),     32'd1);
    chk({tag, "_full"},  32'(full),      32'd0);
`ifdef WFID_DONE_QUEUE_OVFL_ERR_EN
    chk({tag, "_ovfl"},  32'(ovfl_err),  32'd0);
`endif
  endtask

  // At each negedge: compare DUT state against the scoreboard, then advance the
  // scoreboard for the inputs being driven into the next rising edge.
  task automatic tick(input logic done, input logic [5:0] wfid, input logic ack);
    bit pop;
    bit push;
    int sz;
    @(negedge clk);
    sz = exp_q.size();
    chk("valid", 32'(out_valid), 32'(sz != 0));
    chk("count", 32'(count),     32'(sz));
    chk("full",  32'(full),      32'(sz == Depth));
    chk("empty", 32'(empty),     32'(sz == 0));
`ifdef WFID_DONE_QUEUE_OVFL_ERR_EN
    chk("ovfl",  32'(ovfl_err),  32'(m_ovfl));
`endif
    if (sz != 0) begin
      chk("wfid_known", 32'($isunknown(out_wfid)), 32'd0);
      chk("head_wfid",  32'(out_wfid), 32'(exp_q[0]));
    end
    pop  = ack && (sz != 0);
    push = done && ((sz < Depth) || pop);
    if (done && !push) m_ovfl = 1'b1;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(int'(wfid));
    muxed_wfid_done = done;
    muxed_wfid      = done ? wfid : 6'bx;
    out_ack         = ack;
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * Depth && exp_q.size() != 0; i++) tick(1'b0, 6'd0, 1'b1);
    tick(1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    muxed_wfid_done = 1'b0;
    muxed_wfid      = 6'bx;
    out_ack         = 1'b0;
    #12;
    chk_reset_outputs("por");
    rst = 1'b0;

    // Single event, then ack.
    tick(1'b1, 6'd13, 1'b0);
    tick(1'b0, 6'd0, 1'b0);
    tick(1'b0, 6'd0, 1'b1);
    tick(1'b0, 6'd0, 1'b0);

    // Fill with 1..8 in order.
    for (int i = 1; i <= Depth; i++) tick(1'b1, 6'(i), 1'b0);
    // Overflow: 40 must be dropped.
    tick(1'b1, 6'd40, 1'b0);
    tick(1'b0, 6'd0, 1'b0);
    // Full push+pop: 39 enters as 1 leaves.
    tick(1'b1, 6'd39, 1'b1);
    tick(1'b0, 6'd0, 1'b0);
    drain();

    // Duplicates stay separate entries.
    tick(1'b1, 6'd5, 1'b0);
    tick(1'b1, 6'd5, 1'b0);
    tick(1'b1, 6'd63, 1'b1);
    drain();

    // Random traffic with X on muxed_wfid whenever done=0; pointers wrap repeatedly.
    for (int i = 0; i < 60; i++) begin
      tick(1'(($urandom_range(0, 2) != 0)), 6'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)));
    end
    drain();

    // Mid-cycle reset while full discards everything without a clock edge.
    for (int i = 0; i < Depth; i++) tick(1'b1, 6'(20 + i), 1'b0);
    tick(1'b1, 6'd50, 1'b0);
    tick(1'b0, 6'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    exp_q.delete();
    m_ovfl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 6'd7, 1'b0);
    tick(1'b0, 6'd0, 1'b1);
    tick(1'b0, 6'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
